// File: rtl/fpu_issue_ctrl.sv
// Initiator side of the FPU run/done handshake: issues one operation at a time,
// holds the operands, collects result and sticky flags, and aborts via watchdog.
module fpu_issue_ctrl #(
  parameter int DATA_W   = 32,
  parameter int OPCODE_W = 2,
  parameter int TMO_W    = 8,
  parameter int TMO_CYC  = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  input  logic [OPCODE_W-1:0] req_op,
  output logic                fpu_run,
  output logic                fpu_running,
  output logic [DATA_W-1:0]   fpu_in0,
  output logic [DATA_W-1:0]   fpu_in1,
  output logic [OPCODE_W-1:0] fpu_op,
  input  logic [DATA_W-1:0]   fpu_out0,
  input  logic                fpu_done,
  input  logic                fpu_overflow,
  input  logic                fpu_underflow,
  input  logic                fpu_div_by_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [3:0]          rsp_flags
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] CNT_ONE  = TMO_W'(1);

  state_t                state_q, state_d;
  logic [TMO_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            acc_q, acc_d;
  logic                  req_ready_q, req_ready_d;
  logic                  run_q, run_d;
  logic                  running_q, running_d;
  logic [DATA_W-1:0]     in0_q, in0_d;
  logic [DATA_W-1:0]     in1_q, in1_d;
  logic [OPCODE_W-1:0]   op_q, op_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic [3:0]            rsp_flags_q, rsp_flags_d;
  logic [2:0]            flags_now_s;

  assign flags_now_s = {fpu_div_by_zero, fpu_underflow, fpu_overflow};

  // Next-state and next-output logic for the issue/wait/response sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    req_ready_d = req_ready_q;
    run_d       = 1'b0;
    running_d   = running_q;
    in0_d       = in0_q;
    in1_d       = in1_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        running_d   = 1'b0;
        if (req_valid && req_ready_q) begin
          in0_d       = req_a;
          in1_d       = req_b;
          op_d        = req_op;
          acc_d       = 3'b000;
          cnt_d       = '0;
          req_ready_d = 1'b0;
          run_d       = 1'b1;
          running_d   = 1'b1;
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        req_ready_d = 1'b0;
        running_d   = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        running_d = 1'b1;
        acc_d     = acc_q | flags_now_s;
        cnt_d     = cnt_q + CNT_ONE;
        // done takes priority over a coincident watchdog expiry
        if (fpu_done) begin
          rsp_data_d  = fpu_out0;
          rsp_flags_d = {1'b0, acc_q | flags_now_s};
          rsp_valid_d = 1'b1;
          running_d   = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == TMO_LAST) begin
          rsp_data_d  = '0;
          rsp_flags_d = 4'b1000;
          rsp_valid_d = 1'b1;
          running_d   = 1'b0;
          state_d     = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        running_d = 1'b0;
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b0;
        running_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= 3'b000;
      req_ready_q <= 1'b0;
      run_q       <= 1'b0;
      running_q   <= 1'b0;
      in0_q       <= '0;
      in1_q       <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      req_ready_q <= req_ready_d;
      run_q       <= run_d;
      running_q   <= running_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign fpu_run     = run_q;
  assign fpu_running = running_q;
  assign fpu_in0     = in0_q;
  assign fpu_in1     = in1_q;
  assign fpu_op      = op_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_flags   = rsp_flags_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a behavioural FPU stub of programmable latency.
module tb_fpu_issue_ctrl;
  localparam int DW  = 32;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_a = 32'h0, req_b = 32'h0;
  logic [1:0] req_op = 2'b00;
  logic req_ready, fpu_run, fpu_running, rsp_valid;
  logic [31:0] fpu_in0, fpu_in1, rsp_data;
  logic [1:0] fpu_op;
  logic [3:0] rsp_flags;

  logic stub_done = 1'b0, stub_dbz = 1'b0, stub_busy = 1'b0, inj_done = 1'b0;
  logic [31:0] stub_out = 32'h0;
  int stub_cnt = 0;
  int stub_lat = 5;
  int stub_dbz_at = -1;
  wire fpu_done_w = stub_done | inj_done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.DATA_W(32), .OPCODE_W(2), .TMO_W(8), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .fpu_run(fpu_run), .fpu_running(fpu_running),
    .fpu_in0(fpu_in0), .fpu_in1(fpu_in1), .fpu_op(fpu_op),
    .fpu_out0(stub_out), .fpu_done(fpu_done_w),
    .fpu_overflow(1'b0), .fpu_underflow(1'b0), .fpu_div_by_zero(stub_dbz),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags)
  );

  function automatic logic [31:0] stub_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   stub_calc = a + b;
      2'b01:   stub_calc = a - b;
      2'b10:   stub_calc = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      default: stub_calc = a * b;
    endcase
  endfunction

  // FPU stub: with latency L, done is sampled on the (L+3)th edge after acceptance
  always @(negedge clk) begin
    stub_done <= 1'b0;
    stub_dbz  <= 1'b0;
    if (!rst) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else if (fpu_run) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 0;
    end else if (stub_busy) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt + 1 == stub_dbz_at) stub_dbz <= 1'b1;
      if (stub_cnt + 1 == stub_lat + 2) begin
        stub_done <= 1'b1;
        stub_busy <= 1'b0;
        stub_out  <= stub_calc(fpu_op, fpu_in0, fpu_in1);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    for (int i = 0; i < 50; i++) begin
      if (req_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL issue_accept got=no_accept want=accept"); end
  endtask

  task automatic wait_rsp(input int max, output int edges, output int runs);
    edges = 0;
    runs  = (fpu_run === 1'b1) ? 1 : 0;
    while (rsp_valid !== 1'b1 && edges < max) begin
      @(posedge clk); #1;
      edges++;
      if (fpu_run === 1'b1) runs++;
    end
  endtask

  task automatic consume();
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL consume got valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({req_ready, fpu_run, fpu_running, fpu_in0, fpu_in1, fpu_op, rsp_valid, rsp_data, rsp_flags} !== '0) begin
      bad++; $display("FAIL reset_outputs got ready=%b valid=%b data=%h flags=%b want all 0", req_ready, rsp_valid, rsp_data, rsp_flags);
    end
    @(negedge clk); rst = 1'b1; #1;
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_early got=%b want=0", req_ready); end
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_rise got=%b want=1", req_ready); end
  endtask

  task automatic test_add();
    int e, r;
    stub_lat = 5; stub_dbz_at = -1;
    issue(32'h3, 32'h4, 2'b00);
    total++;
    if (fpu_running !== 1'b1 || req_ready !== 1'b0) begin
      bad++; $display("FAIL add_issue got running=%b ready=%b want running=1 ready=0", fpu_running, req_ready);
    end
    wait_rsp(40, e, r);
    total++; if (r !== 1) begin bad++; $display("FAIL add_run_cycles got=%0d want=1", r); end
    total++; if (e !== 8) begin bad++; $display("FAIL add_latency got=%0d want=8", e); end
    total++; if (rsp_data !== 32'h7) begin bad++; $display("FAIL add_data got=%h want=00000007", rsp_data); end
    total++; if (rsp_flags !== 4'b0000 || fpu_running !== 1'b0) begin
      bad++; $display("FAIL add_flags got flags=%b running=%b want 0000 0", rsp_flags, fpu_running);
    end
    consume();
  endtask

  task automatic test_div_sticky();
    int e, r;
    stub_lat = 5; stub_dbz_at = 3;
    issue(32'h1, 32'h0, 2'b10);
    wait_rsp(40, e, r);
    stub_dbz_at = -1;
    total++; if (e !== 8) begin bad++; $display("FAIL div_latency got=%0d want=8", e); end
    total++; if (rsp_flags !== 4'b0100) begin bad++; $display("FAIL div_sticky_flags got=%b want=0100", rsp_flags); end
    total++; if (rsp_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_data got=%h want=ffffffff", rsp_data); end
    consume();
  endtask

  task automatic test_timeout();
    int e, r, stray;
    stub_lat = 1000;
    issue(32'h5, 32'h6, 2'b11);
    wait_rsp(60, e, r);
    total++; if (e !== TMO + 1) begin bad++; $display("FAIL tmo_edges got=%0d want=%0d", e, TMO + 1); end
    total++; if (rsp_data !== 32'h0 || rsp_flags !== 4'b1000) begin
      bad++; $display("FAIL tmo_rsp got data=%h flags=%b want 00000000 1000", rsp_data, rsp_flags);
    end
    consume();
    @(negedge clk); inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL tmo_stray_done got=%0d bad cycles want=0", stray); end
  endtask

  task automatic test_done_at_timeout();
    int e, r;
    stub_lat = TMO - 2;
    issue(32'd10, 32'd3, 2'b01);
    wait_rsp(60, e, r);
    total++; if (e !== TMO + 1) begin bad++; $display("FAIL tie_edges got=%0d want=%0d", e, TMO + 1); end
    total++; if (rsp_flags !== 4'b0000 || rsp_data !== 32'h7) begin
      bad++; $display("FAIL tie_rsp got data=%h flags=%b want 00000007 0000", rsp_data, rsp_flags);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int e, r, unstable;
    stub_lat = 5;
    issue(32'h10, 32'h20, 2'b00);
    wait_rsp(40, e, r);
    total++; if (rsp_data !== 32'h30) begin bad++; $display("FAIL b2b_first_data got=%h want=00000030", rsp_data); end
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'h1; req_b = 32'h1; req_op = 2'b00; rsp_ready = 1'b0;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h30 || rsp_flags !== 4'b0000 || req_ready !== 1'b0 ||
          fpu_in0 !== 32'h10 || fpu_in1 !== 32'h20) unstable++;
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL b2b_hold got=%0d unstable cycles want=0", unstable); end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || fpu_in0 !== 32'h10) begin
      bad++; $display("FAIL b2b_handshake got valid=%b ready=%b in0=%h want 0 1 00000010", rsp_valid, req_ready, fpu_in0);
    end
    @(posedge clk); #1; req_valid = 1'b0;
    total++;
    if (fpu_in0 !== 32'h1 || fpu_in1 !== 32'h1 || fpu_run !== 1'b1 || req_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_second_accept got in0=%h in1=%h run=%b ready=%b want 1 1 1 0", fpu_in0, fpu_in1, fpu_run, req_ready);
    end
    wait_rsp(40, e, r);
    total++; if (e !== 8 || rsp_data !== 32'h2) begin bad++; $display("FAIL b2b_second_rsp got edges=%0d data=%h want 8 00000002", e, rsp_data); end
    consume();
  endtask

  task automatic test_reset_mid_op();
    int e, r;
    stub_lat = 5;
    issue(32'h5, 32'h5, 2'b00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2; rst = 1'b0; #1;
    total++;
    if ({req_ready, fpu_run, fpu_running, fpu_in0, fpu_in1, fpu_op, rsp_valid, rsp_data, rsp_flags} !== '0) begin
      bad++; $display("FAIL midrst_outputs got ready=%b running=%b in0=%h valid=%b want all 0", req_ready, fpu_running, fpu_in0, rsp_valid);
    end
    @(negedge clk); @(negedge clk); rst = 1'b1; #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready_early got=%b want=0", req_ready); end
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_idle got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    issue(32'd6, 32'd7, 2'b11);
    wait_rsp(40, e, r);
    total++; if (e !== 8 || rsp_data !== 32'd42 || rsp_flags !== 4'b0000) begin
      bad++; $display("FAIL midrst_mul got edges=%0d data=%h flags=%b want 8 0000002a 0000", e, rsp_data, rsp_flags);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_div_sticky();
    test_timeout();
    test_done_at_timeout();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
